cypher_emitter: RTL

//  Transmit side of the cypher link: serialises a loaded 16-bit cypher into a 4-bit digit stream for cypher_detector.

---
 rtl/cypher_pkg.sv | 26 ++
 rtl/cypher_lfsr4.sv | 26 ++
 rtl/cypher_emitter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cypher_pkg.sv
// Shared definitions for the cypher link (emitter and detector).
// Holds the FSM state encoding, the digit width, default sizing and the
// filler masking helper used by the noise build of the emitter.
package cypher_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } cypher_state_e;

   localparam int DIGIT_W        = 4;
   localparam int DEFAULT_DIGITS = 4;
   localparam int DEFAULT_SUM_W  = 8;

   // A filler digit equal to the first cypher digit is inverted so the
   // detector can never begin a match inside the filler run.
   function automatic logic [DIGIT_W-1:0] maskFiller(
      input logic [DIGIT_W-1:0] filler,
      input logic [DIGIT_W-1:0] firstDigit
   );
      return (filler == firstDigit) ? ~filler : filler;
   endfunction

endpackage

// File: rtl/cypher_lfsr4.sv
// 4-bit Fibonacci LFSR, polynomial x^4+x^3+1, maximal length (period 15).
// Seeds to 4'b0001 on reset and advances only when step_i is high.
// next_o exposes the value the register will take on the next step.
module cypher_lfsr4 (
   input  logic       clock,
   input  logic       reset,
   input  logic       step_i,
   output logic [3:0] value_o,
   output logic [3:0] next_o
);

   logic [3:0] lfsr_q;

   assign next_o  = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
   assign value_o = lfsr_q;

   // Hold the seed under reset, otherwise shift once per requested step.
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_q <= 4'b0001;
      end else if (step_i) begin
         lfsr_q <= next_o;
      end
   end

endmodule

// File: rtl/cypher_emitter.sv
// Transmit side of the cypher link: serialises a loaded cypher into a
// least-significant-nibble-first digit stream with a valid/ready handshake,
// keeping a running digit sum that mirrors the detector.
// Optional feature: define CYPHER_EMITTER_NOISE_EN to add the FILL state,
// which sends gap_len LFSR filler digits ahead of the cypher.
module cypher_emitter
   import cypher_pkg::*;
#(
   parameter int DIGITS = DEFAULT_DIGITS,
   parameter int SUM_W  = DEFAULT_SUM_W,
   parameter int GAP_W  = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   cypher_in,
   input  logic                  load,
   input  logic                  start,
   input  logic [GAP_W-1:0]      gap_len,
   input  logic                  num_ready,
   output logic [DIGIT_W-1:0]    num,
   output logic                  num_valid,
   output logic [SUM_W-1:0]      sum,
   output logic                  busy,
   output logic                  done
);

   localparam int CYPHER_W = DIGIT_W * DIGITS;
   localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W    = (IDX_W > GAP_W) ? IDX_W : GAP_W;

   cypher_state_e         state_q;
   logic [CYPHER_W-1:0]   cypher_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DIGIT_W-1:0]    num_q;
   logic                  numValid_q;
   logic [SUM_W-1:0]      sum_q;
   logic                  busy_q;
   logic                  done_q;

   logic                  accept;
   logic                  lastDigit;
   logic [CYPHER_W-1:0]   cypherEff;
   logic [DIGIT_W-1:0]    nextDigit_d;
   logic [SUM_W-1:0]      sum_d;

   assign accept    = numValid_q & num_ready;
   assign lastDigit = (cnt_q == CNT_W'(DIGITS - 1));
   assign cypherEff = load ? cypher_in : cypher_q;
   assign sum_d     = sum_q + SUM_W'(num_q);

`ifdef CYPHER_EMITTER_NOISE_EN
   logic [GAP_W-1:0]   gap_q;
   logic [DIGIT_W-1:0] lfsrValue;
   logic [DIGIT_W-1:0] lfsrNext;
   logic               lfsrStep;
   logic               lastFiller;

   assign lfsrStep   = (state_q == FILL) & accept;
   assign lastFiller = (cnt_q == (CNT_W'(gap_q) - CNT_W'(1)));

   cypher_lfsr4 u_lfsr (
      .clock   (clock),
      .reset   (reset),
      .step_i  (lfsrStep),
      .value_o (lfsrValue),
      .next_o  (lfsrNext)
   );
`else
   logic unusedGap;
   assign unusedGap = ^gap_len;
`endif

   // Pick the cypher digit that follows the one currently on the bus.
   always_comb begin
      nextDigit_d = DIGIT_W'(cypher_q >> (DIGIT_W * (int'(cnt_q) + 1)));
   end

   // Main FSM: capture, handshake-driven digit stepping, sum and done pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cypher_q   <= '0;
         cnt_q      <= '0;
         num_q      <= '0;
         numValid_q <= 1'b0;
         sum_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef CYPHER_EMITTER_NOISE_EN
         gap_q      <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load) begin
                  cypher_q <= cypher_in;
               end
               if (start) begin
                  sum_q      <= '0;
                  cnt_q      <= '0;
                  numValid_q <= 1'b1;
                  busy_q     <= 1'b1;
`ifdef CYPHER_EMITTER_NOISE_EN
                  gap_q <= gap_len;
                  if (gap_len != '0) begin
                     state_q <= FILL;
                     num_q   <= maskFiller(lfsrValue, cypherEff[DIGIT_W-1:0]);
                  end else begin
                     state_q <= SEND;
                     num_q   <= cypherEff[DIGIT_W-1:0];
                  end
`else
                  state_q <= SEND;
                  num_q   <= cypherEff[DIGIT_W-1:0];
`endif
               end
            end
`ifdef CYPHER_EMITTER_NOISE_EN
            FILL: begin
               if (accept) begin
                  sum_q <= sum_d;
                  if (lastFiller) begin
                     state_q <= SEND;
                     cnt_q   <= '0;
                     num_q   <= cypher_q[DIGIT_W-1:0];
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                     num_q <= maskFiller(lfsrNext, cypher_q[DIGIT_W-1:0]);
                  end
               end
            end
`endif
            SEND: begin
               if (accept) begin
                  sum_q <= sum_d;
                  if (lastDigit) begin
                     state_q    <= DONE;
                     numValid_q <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                     num_q <= nextDigit_d;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               numValid_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign num       = num_q;
   assign num_valid = numValid_q;
   assign sum       = sum_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
